dmem_responder: RTL

Memory-side responder for the core's data-memory load/store interface. It accepts one request at a time over a valid/ready handshake and generates byte-lane masks from func3 and the address LSBs. It aligns and sign- or zero-extends load data, inserts a configurable number of wait states, and returns the result over a response handshake. It replaces the bare combinational data memory between the core datapath and a word-organised storage array.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/load_align.sv | 29 ++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: func3 encodings, FSM states,
// byte-lane mask and request legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  function automatic logic [3:0] byte_mask(input logic [2:0] func3, input logic [1:0] addr_lsb);
    logic [3:0] m;
    case (func3)
      F3_B, F3_BU: m = 4'b0001 << addr_lsb;
      F3_H, F3_HU: m = 4'b0011 << addr_lsb;
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

  // Misaligned access, unknown size, unsigned store, or not exactly one of ld/str.
  function automatic logic req_error(input logic [2:0] func3, input logic [1:0] addr_lsb,
                                     input logic is_load, input logic is_store);
    logic e;
    case (func3)
      F3_B:    e = 1'b0;
      F3_H:    e = addr_lsb[0];
      F3_W:    e = |addr_lsb;
      F3_BU:   e = is_store;
      F3_HU:   e = is_store | addr_lsb[0];
      default: e = 1'b1;
    endcase
    return e | (is_load == is_store);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/halfword addressed by addr_lsb
// out of a storage word and sign- or zero-extends it according to func3.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word_i >> {addr_lsb_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = shifted[15:0];
    case (func3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request, programmable
// wait states, masked word storage and aligned/extended load responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic              req_ld,
  input  logic              req_str,
  input  logic [2:0]        req_func3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_e       state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        func3_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ld_q, str_q, err_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, req_err, commit, wr_en;
  logic              cur_ld, cur_str, cur_err;
  logic [ADDR_W+1:0] cur_addr;
  logic [2:0]        cur_func3;
  logic [DATA_W-1:0] cur_wdata, wdata_rep, rd_word, aligned, load_result;
  logic [3:0]        wr_mask;
  logic [ADDR_W-1:0] word_idx;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_err   = req_error(req_func3, req_addr[1:0], req_ld, req_str);

  // With zero wait states the commit happens on the accept edge, before the
  // request fields have been latched, so the live inputs are used instead.
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_func3 = (state_q == IDLE) ? req_func3 : func3_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_ld    = (state_q == IDLE) ? req_ld    : ld_q;
  assign cur_str   = (state_q == IDLE) ? req_str   : str_q;
  assign cur_err   = (state_q == IDLE) ? req_err   : err_q;

  assign commit = ((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));
  assign wr_en    = commit & cur_str & ~cur_err;
  assign wr_mask  = byte_mask(cur_func3, cur_addr[1:0]);
  assign word_idx = cur_addr[ADDR_W+1:2];

  always_comb begin
    case (cur_func3[1:0])
      2'b00:   wdata_rep = {4{cur_wdata[7:0]}};
      2'b01:   wdata_rep = {2{cur_wdata[15:0]}};
      default: wdata_rep = cur_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[word_idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
    end
  end

  assign rd_word = mem[word_idx];

  load_align u_load_align (
    .word_i     (rd_word),
    .addr_lsb_i (cur_addr[1:0]),
    .func3_i    (cur_func3),
    .data_o     (aligned)
  );

  assign load_result = (cur_ld && !cur_err) ? aligned : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      func3_q     <= 3'd0;
      wdata_q     <= '0;
      ld_q        <= 1'b0;
      str_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            func3_q <= req_func3;
            wdata_q <= req_wdata;
            ld_q    <= req_ld;
            str_q   <= req_str;
            err_q   <= req_err;
            if (WAIT_STATES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_result;
              rsp_err_q   <= cur_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_result;
            rsp_err_q   <= cur_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
